// File: rtl/phy_link_pkg.sv
// Shared definitions for the byte-serial flit link: widths, frame byte slices and
// the receive FSM state encoding.
package phy_link_pkg;

    localparam int unsigned FLIT_W         = 18;
    localparam int unsigned BYTE_W         = 8;
    localparam int unsigned FLIT_VALID_BIT = 17;

    // Where each frame byte lands in the flit.
    localparam int unsigned B0_HI = 17;
    localparam int unsigned B0_LO = 16;
    localparam int unsigned B1_HI = 15;
    localparam int unsigned B1_LO = 8;
    localparam int unsigned B2_HI = 7;
    localparam int unsigned B2_LO = 0;

    // Bit of byte 0 that carries the flit-valid marker.
    localparam int unsigned MARK_BIT = FLIT_VALID_BIT - B0_LO;

    typedef logic [FLIT_W-1:0] flit_t;
    typedef logic [BYTE_W-1:0] byte_t;

    typedef logic [1:0] rx_state_t;
    localparam rx_state_t StIdle = 2'd0;
    localparam rx_state_t StB1   = 2'd1;
    localparam rx_state_t StB2   = 2'd2;

    function automatic flit_t assemble_flit(input logic [FLIT_W-1:BYTE_W] hi, input byte_t lo);
        return {hi, lo};
    endfunction

endpackage

// File: rtl/phy_flit_fifo.sv
// Show-ahead synchronous flit FIFO; the head is presented from a register and a new
// entry is never bypassed to the head in the cycle it is written.
module phy_flit_fifo
    import phy_link_pkg::*;
#(
    parameter int unsigned DEPTH = 32
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     wr_i,
    input  flit_t                    wr_data_i,
    output logic                     wr_ok_o,
    output logic                     wr_drop_o,
    input  logic                     rd_ready_i,
    output logic                     rd_valid_o,
    output flit_t                    rd_data_o,
    output logic [$clog2(DEPTH):0]   occupancy_o
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [AW:0] wr_ptr_q, wr_ptr_d;
    logic [AW:0] rd_ptr_q, rd_ptr_d;
    logic        valid_q;
    flit_t       data_q;
    flit_t       mem_q [DEPTH];

    logic full;
    logic pop;
    logic push;
    logic head_avail;

    assign full = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign pop  = valid_q & rd_ready_i;
    // A pop frees the slot in the same cycle, so a full FIFO still accepts a write then.
    assign push = wr_i & (~full | pop);

    assign wr_ok_o   = push;
    assign wr_drop_o = wr_i & full & ~pop;

    assign wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, push};
    assign rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, pop};

    // Compare against the pre-write pointer: the entry written now shows up next cycle.
    assign head_avail = (wr_ptr_q != rd_ptr_d);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            valid_q  <= 1'b0;
            data_q   <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            valid_q  <= head_avail;
            data_q   <= head_avail ? mem_q[rd_ptr_d[AW-1:0]] : '0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push) begin
            mem_q[wr_ptr_q[AW-1:0]] <= wr_data_i;
        end
    end

    assign rd_valid_o  = valid_q;
    assign rd_data_o   = data_q;
    assign occupancy_o = wr_ptr_q - rd_ptr_q;

endmodule

// File: rtl/phy_link_rx.sv
// Receive end of the inter-FPGA byte-serial flit link: oversamples the forwarded strobe,
// reassembles 3-byte frames into flits and queues them for the router port.
module phy_link_rx
    import phy_link_pkg::*;
#(
    parameter int unsigned DEPTH        = 32,
    parameter int unsigned AFULL_MARGIN = 4,
    parameter int unsigned TIMEOUT      = 15
) (
    input  logic              CLK,
    input  logic              rst,
    input  logic              sync_clk_in,
    input  logic [7:0]        serial_data_in,
    output logic [17:0]       output_data_to_router,
    output logic              out_valid,
    input  logic              router_ready,
    output logic              link_ready,
    output logic [15:0]       flit_count,
    output logic [7:0]        drop_count
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned TW = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0] TMO_MAX   = TW'(TIMEOUT);
    localparam logic [AW:0]   AFULL_LVL = (AW + 1)'(DEPTH - AFULL_MARGIN);

    logic s1_q, s2_q, s3_q;
    byte_t d1_q, d2_q;
    logic strobe_edge;

    rx_state_t state_q, state_d;
    logic [FLIT_W-1:BYTE_W] hold_q, hold_d;
    logic [TW-1:0] tmo_cnt_q, tmo_cnt_d;
    logic tmo_drop;

    logic  wr_q, wr_d;
    flit_t wr_flit_q, wr_flit_d;

    logic        link_ready_q;
    logic [15:0] flit_count_q, flit_count_d;
    logic [7:0]  drop_count_q, drop_count_d;

    logic        fifo_wr_ok;
    logic        fifo_wr_drop;
    logic [AW:0] fifo_occ;

    // Strobe and data share the same flop depth so d2 is stable whenever the edge fires.
    always_ff @(posedge CLK) begin
        if (rst) begin
            s1_q <= 1'b0;
            s2_q <= 1'b0;
            s3_q <= 1'b0;
            d1_q <= '0;
            d2_q <= '0;
        end else begin
            s1_q <= sync_clk_in;
            s2_q <= s1_q;
            s3_q <= s2_q;
            d1_q <= serial_data_in;
            d2_q <= d1_q;
        end
    end

    assign strobe_edge = s2_q & ~s3_q;

    always_comb begin
        state_d   = state_q;
        hold_d    = hold_q;
        wr_d      = 1'b0;
        wr_flit_d = wr_flit_q;
        tmo_drop  = 1'b0;

        if (strobe_edge) begin
            tmo_cnt_d = '0;
        end else if (tmo_cnt_q != TMO_MAX) begin
            tmo_cnt_d = tmo_cnt_q + TW'(1);
        end else begin
            tmo_cnt_d = tmo_cnt_q;
        end

        case (state_q)
            StIdle: begin
                if (strobe_edge && d2_q[MARK_BIT]) begin
                    hold_d[B0_HI:B0_LO] = d2_q[B0_HI-B0_LO:0];
                    state_d             = StB1;
                end
            end
            StB1: begin
                if (strobe_edge) begin
                    hold_d[B1_HI:B1_LO] = d2_q;
                    state_d             = StB2;
                end else if (tmo_cnt_q == TMO_MAX) begin
                    hold_d   = '0;
                    tmo_drop = 1'b1;
                    state_d  = StIdle;
                end
            end
            StB2: begin
                if (strobe_edge) begin
                    wr_d      = 1'b1;
                    wr_flit_d = assemble_flit(hold_q, d2_q);
                    state_d   = StIdle;
                end else if (tmo_cnt_q == TMO_MAX) begin
                    hold_d   = '0;
                    tmo_drop = 1'b1;
                    state_d  = StIdle;
                end
            end
            default: begin
                hold_d  = '0;
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (rst) begin
            state_q   <= StIdle;
            hold_q    <= '0;
            tmo_cnt_q <= '0;
            wr_q      <= 1'b0;
            wr_flit_q <= '0;
        end else begin
            state_q   <= state_d;
            hold_q    <= hold_d;
            tmo_cnt_q <= tmo_cnt_d;
            wr_q      <= wr_d;
            wr_flit_q <= wr_flit_d;
        end
    end

    phy_flit_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk_i       (CLK),
        .rst_i       (rst),
        .wr_i        (wr_q),
        .wr_data_i   (wr_flit_q),
        .wr_ok_o     (fifo_wr_ok),
        .wr_drop_o   (fifo_wr_drop),
        .rd_ready_i  (router_ready),
        .rd_valid_o  (out_valid),
        .rd_data_o   (output_data_to_router),
        .occupancy_o (fifo_occ)
    );

    always_comb begin
        logic [8:0] drop_sum;
        flit_count_d = flit_count_q + {15'd0, fifo_wr_ok};
        drop_sum     = {1'b0, drop_count_q} + {8'd0, tmo_drop} + {8'd0, fifo_wr_drop};
        drop_count_d = drop_sum[8] ? 8'hFF : drop_sum[7:0];
    end

    always_ff @(posedge CLK) begin
        if (rst) begin
            link_ready_q <= 1'b0;
            flit_count_q <= '0;
            drop_count_q <= '0;
        end else begin
            link_ready_q <= (fifo_occ < AFULL_LVL);
            flit_count_q <= flit_count_d;
            drop_count_q <= drop_count_d;
        end
    end

    assign link_ready = link_ready_q;
    assign flit_count = flit_count_q;
    assign drop_count = drop_count_q;

endmodule

// File: doc/phy_link_rx.md
Name: phy_link_rx

Overview:
- Receive end of the inter-FPGA byte-serial flit link.
- Takes the forwarded strobe `sync_clk_in` and 8-bit `serial_data_in` from the far-end serializer, and samples both in the local `CLK` domain with synchronizers and edge detection (the strobe is never used as a clock).
- Reassembles each 3-byte frame into an 18-bit flit, buffers it in a FIFO, and presents it to the local router port with a valid/ready handshake.
- Drives a `link_ready` level back to the far end for flow control.

Parameters:
- `DEPTH`, 32: FIFO entries; power of two, at least 4.
- `AFULL_MARGIN`, 4: `link_ready` deasserts when occupancy >= `DEPTH - AFULL_MARGIN`.
- `TIMEOUT`, 15: `CLK` cycles without a strobe rising edge in B1 or B2 before the partial frame is discarded.

Ports:
- `CLK` in 1: sole clock.
- `rst` in 1: synchronous, active-high reset.
- `sync_clk_in` in 1: forwarded strobe; data is valid at its rising edge.
- `serial_data_in` in 8: link byte.
- `output_data_to_router` out 18: FIFO head flit; bit 17 is the flit-valid marker.
- `out_valid` out 1: head flit present.
- `router_ready` in 1: router accepts the head flit this cycle.
- `link_ready` out 1: far end may start new frames.
- `flit_count` out 16: flits written to the FIFO; wraps at 65535 -> 0.
- `drop_count` out 8: flits lost to overflow or timeout; saturates at 255.

Behaviour:
- Link framing (transmitter rule):
  - Byte 0 = {6'b0, flit[17:16]}, byte 1 = flit[15:8], byte 2 = flit[7:0], then a 0x00 filler byte.
  - One strobe rising edge per byte.
  - Strobe high and low phases each last at least 2 receiver `CLK` cycles.
- Input sampling:
  - `sync_clk_in` passes through flops `s1`, `s2`, `s3`; `edge = s2 & ~s3`.
  - `serial_data_in` passes through `d1`, `d2`, aligned with `s2`.
  - The FSM samples `d2` only in cycles where `edge` is 1.
- FSM states:
  - IDLE: on `edge` with `d2[1]==1`, load `hold[17:16] = d2[1:0]` and go to B1. On `edge` with `d2[1]==0` (filler or noise), ignore and stay in IDLE.
  - B1: on `edge`, `hold[15:8] = d2` and go to B2.
  - B2: on `edge`, write `{hold[17:8], d2}` into the FIFO and go to IDLE.
  - Timeout: a cycle counter clears on every `edge`. In B1 or B2, when the counter reaches `TIMEOUT`, go to IDLE, discard the partial frame and increment `drop_count`.
- FIFO write:
  - Registered on the `CLK` edge that ends the B2 `edge` cycle.
  - `out_valid` and `output_data_to_router` appear the following cycle: show-ahead FIFO, head presented from a register.
  - Latency from the cycle `s1` first captures byte 2's strobe high to `out_valid` = 4 `CLK` cycles when the FIFO was empty.
- Router handshake:
  - A pop occurs when `out_valid & router_ready`.
  - `output_data_to_router` is held stable while `out_valid & ~router_ready`.
  - When the FIFO is empty, `out_valid` = 0 and `output_data_to_router` = 0.
- Full FIFO:
  - Write with no simultaneous pop: the flit is dropped and `drop_count` increments.
  - Write and pop in the same cycle: both occur and occupancy is unchanged.
  - Empty FIFO and write in the same cycle: no bypass; the flit becomes visible next cycle.
- Pointers are `log2(DEPTH)+1` bits and wrap modulo `2*DEPTH`. Full means the MSBs differ and the remaining bits are equal.
- `link_ready` is registered. It is 0 when occupancy >= `DEPTH - AFULL_MARGIN`, otherwise 1.
- Reset, including mid-frame:
  - FSM goes to IDLE, `hold` is cleared and pointers are zeroed; FIFO contents are not cleared, but the FIFO reads as empty.
  - Sync and data flops are cleared to 0.
  - Outputs: `out_valid`=0, `output_data_to_router`=0, `link_ready`=0 during reset and 1 the first cycle after, `flit_count`=0, `drop_count`=0.
  - After reset, a partial frame in flight is not recognized unless its next byte has bit 1 set.

Decomposition:
- Shared package `phy_link_pkg`:
  - `FLIT_W=18`, `BYTE_W=8`.
  - Frame byte-slice constants.
  - The FSM state enum (IDLE/B1/B2).
  - `FLIT_VALID_BIT=17`.
- One sub-module `phy_flit_fifo` (parameter `DEPTH`, 18-bit show-ahead sync FIFO with occupancy output), reusable by the transmit side.

Test Plan:
- Single frame: bytes 0x02, 0xAB, 0xCD, 0x00 with 2-cycle strobe phases -> exactly one flit `0x2ABCD`, `out_valid` 4 cycles after byte 2's strobe rises, `flit_count`=1.
- Filler/noise only: 10 strobe edges with data 0x00 or 0x01 -> `out_valid` stays 0, `flit_count`=0, `drop_count`=0.
- Timeout: send 0x03 and 0x11, then hold the strobe low for 20 cycles, then a full frame 0x02, 0x00, 0x05 -> `drop_count`=1, only `0x20005` delivered.
- Backpressure and overflow (`DEPTH`=32) with `router_ready`=0:
  - After 28 flits, `link_ready`=0.
  - Flits 33 and 34 are dropped (`drop_count`=2); the head is still flit 1 and stays stable.
  - Then `router_ready`=1 delivers 32 flits in order.
- Full with simultaneous pop: FIFO full, `router_ready`=1 in the same cycle as a B2 write -> occupancy stays 32, no drop.
- Reset mid-frame: `rst` for 1 cycle after byte 1, then send bytes 0xCD, 0x00 and a full frame 0x02, 0x12, 0x34 -> no output from the partial frame, one flit `0x21234`, counters zero before the flit arrives.
